// File: rtl/fnd_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fnd_scan_ctrl_if
// Brief    : Stopwatch count inputs and 7-segment drive lines for fnd_scan_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface fnd_scan_ctrl_if;
    logic       sw_mode;
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [3:0] fnd_com;
    logic [7:0] fnd_data;

    // master: the stopwatch datapath side; slave: the display controller
    modport master (
        output sw_mode, msec, sec, min, hour,
        input  fnd_com, fnd_data
    );

    modport slave (
        input  sw_mode, msec, sec, min, hour,
        output fnd_com, fnd_data
    );
endinterface
`default_nettype wire

// File: rtl/fnd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fnd_scan_ctrl
// Brief    : 4-digit common-anode 7-segment scanner showing SS.CC or HH.MM
//            from a per-frame snapshot. Optional macro FND_DOT_BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fnd_scan_ctrl #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int SCAN_HZ     = 1000
) (
    input  wire logic     clk,
    input  wire logic     rst,
    fnd_scan_ctrl_if.slave bus
);

    localparam int c_div   = CLK_FREQ_HZ / SCAN_HZ;
    localparam int c_cnt_w = (c_div > 2) ? $clog2(c_div) : 1;
    localparam logic [c_cnt_w-1:0] c_tick_last = c_cnt_w'(c_div - 1);

    logic [c_cnt_w-1:0] r_tick_cnt;
    logic [1:0]         r_digit_sel;
    logic               r_snap_mode;
    logic [6:0]         r_snap_msec;
    logic [5:0]         r_snap_sec;
    logic [5:0]         r_snap_min;
    logic [4:0]         r_snap_hour;
    logic [3:0]         r_fnd_com;
    logic [7:0]         r_fnd_data;

    logic               w_tick;
    logic [3:0]         w_msec_tens, w_msec_ones;
    logic [3:0]         w_sec_tens,  w_sec_ones;
    logic [3:0]         w_min_tens,  w_min_ones;
    logic [3:0]         w_hour_tens, w_hour_ones;
    logic [3:0]         w_digit;
    logic [6:0]         w_seg;
    logic               w_dp_on;
    logic [3:0]         w_com_next;
    logic [7:0]         w_data_next;

    assign w_tick = (r_tick_cnt == c_tick_last);

    // Tens digits keep the full quotient so out-of-range counts decode blank.
    assign w_msec_tens = 4'(r_snap_msec / 7'd10);
    assign w_msec_ones = 4'(r_snap_msec % 7'd10);
    assign w_sec_tens  = 4'(r_snap_sec  / 6'd10);
    assign w_sec_ones  = 4'(r_snap_sec  % 6'd10);
    assign w_min_tens  = 4'(r_snap_min  / 6'd10);
    assign w_min_ones  = 4'(r_snap_min  % 6'd10);
    assign w_hour_tens = 4'(r_snap_hour / 5'd10);
    assign w_hour_ones = 4'(r_snap_hour % 5'd10);

    always_comb begin
        w_digit = 4'd0;
        case (r_digit_sel)
            2'd0:    w_digit = r_snap_mode ? w_min_ones  : w_msec_ones;
            2'd1:    w_digit = r_snap_mode ? w_min_tens  : w_msec_tens;
            2'd2:    w_digit = r_snap_mode ? w_hour_ones : w_sec_ones;
            default: w_digit = r_snap_mode ? w_hour_tens : w_sec_tens;
        endcase
    end

    always_comb begin
        w_seg = 7'h7F;
        case (w_digit)
            4'd0:    w_seg = 7'h40;
            4'd1:    w_seg = 7'h79;
            4'd2:    w_seg = 7'h24;
            4'd3:    w_seg = 7'h30;
            4'd4:    w_seg = 7'h19;
            4'd5:    w_seg = 7'h12;
            4'd6:    w_seg = 7'h02;
            4'd7:    w_seg = 7'h78;
            4'd8:    w_seg = 7'h00;
            4'd9:    w_seg = 7'h10;
            default: w_seg = 7'h7F;
        endcase
    end

`ifdef FND_DOT_BLINK_EN
    assign w_dp_on = (r_digit_sel == 2'd2) && (r_snap_msec < 7'd50);
`else
    assign w_dp_on = (r_digit_sel == 2'd2);
`endif

    assign w_com_next  = ~(4'b0001 << r_digit_sel);
    assign w_data_next = {~w_dp_on, w_seg};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tick_cnt  <= '0;
            r_digit_sel <= 2'd0;
            r_snap_mode <= 1'b0;
            r_snap_msec <= 7'd0;
            r_snap_sec  <= 6'd0;
            r_snap_min  <= 6'd0;
            r_snap_hour <= 5'd0;
            r_fnd_com   <= 4'hF;
            r_fnd_data  <= 8'hFF;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            if (w_tick) begin
                r_digit_sel <= r_digit_sel + 2'd1;
            end
            // Snapshot on the frame wrap so a whole frame shows one coherent time.
            if (w_tick && (r_digit_sel == 2'd3)) begin
                r_snap_mode <= bus.sw_mode;
                r_snap_msec <= bus.msec;
                r_snap_sec  <= bus.sec;
                r_snap_min  <= bus.min;
                r_snap_hour <= bus.hour;
            end
            r_fnd_com  <= w_com_next;
            r_fnd_data <= w_data_next;
        end
    end

    assign bus.fnd_com  = r_fnd_com;
    assign bus.fnd_data = r_fnd_data;

endmodule
`default_nettype wire

// File: tb/tb_fnd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fnd_scan_ctrl
// Brief    : Scoreboard bench for fnd_scan_ctrl with DIV = 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fnd_scan_ctrl;

    typedef struct {
        string      tag;
        logic [11:0] exp;
    } sb_entry_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    sb_entry_t sb_q[$];

    fnd_scan_ctrl_if bus ();

    fnd_scan_ctrl #(
        .CLK_FREQ_HZ (8),
        .SCAN_HZ     (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_seg(input int v, input bit dp);
        logic [7:0] s;
        case (v)
            0: s = 8'hC0;  1: s = 8'hF9;  2: s = 8'hA4;  3: s = 8'hB0;
            4: s = 8'h99;  5: s = 8'h92;  6: s = 8'h82;  7: s = 8'hF8;
            8: s = 8'h80;  9: s = 8'h90;
            default: s = 8'hFF;
        endcase
        if (dp) s[7] = 1'b0;
        return s;
    endfunction

    task automatic push_frame(input string tag, input bit mode, input int ms, input int s,
                              input int mi, input int h, input int first, input int last);
        int dg[4];
        if (mode) begin
            dg[0] = mi % 10; dg[1] = mi / 10; dg[2] = h % 10; dg[3] = h / 10;
        end else begin
            dg[0] = ms % 10; dg[1] = ms / 10; dg[2] = s % 10; dg[3] = s / 10;
        end
        for (int d = first; d <= last; d++) begin
            sb_entry_t e;
            logic [3:0] com;
            bit dp;
            com = 4'b1111;
            com[d] = 1'b0;
`ifdef FND_DOT_BLINK_EN
            dp = (d == 2) && (ms < 50);
`else
            dp = (d == 2);
`endif
            e.tag = $sformatf("%s_d%0d", tag, d);
            e.exp = {com, exp_seg(dg[d], dp)};
            sb_q.push_back(e);
        end
    endtask

    // Returns at a negedge sample point where fnd_com equals v.
    task automatic wait_for_com(input logic [3:0] v, input string tag);
        for (int i = 0; i < 64; i++) begin
            if (bus.fnd_com === v) return;
            @(negedge clk);
        end
        check({tag, "_timeout"}, {bus.fnd_com, 8'h00}, {v, 8'h00});
    endtask

    // Next digit 0 whose snapshot was taken after the current sample point.
    task automatic wait_new_frame();
        wait_for_com(4'b1011, "frame_d2");
        wait_for_com(4'b1110, "frame_d0");
    endtask

    task automatic capture(input int first, input int last);
        for (int d = first; d <= last; d++) begin
            sb_entry_t e;
            logic [3:0] com;
            com = 4'b1111;
            com[d] = 1'b0;
            wait_for_com(com, "scan");
            e = sb_q.pop_front();
            check(e.tag, {bus.fnd_com, bus.fnd_data}, e.exp);
        end
    endtask

    task automatic apply(input string tag, input bit mode, input int ms, input int s,
                         input int mi, input int h);
        @(negedge clk);
        bus.sw_mode = mode;
        bus.msec    = 7'(ms);
        bus.sec     = 6'(s);
        bus.min     = 6'(mi);
        bus.hour    = 5'(h);
        push_frame(tag, mode, ms, s, mi, h, 0, 3);
        wait_new_frame();
        capture(0, 3);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        bus.sw_mode = 1'b0;
        bus.msec = 7'd0;
        bus.sec  = 6'd0;
        bus.min  = 6'd0;
        bus.hour = 5'd0;

        repeat (3) @(negedge clk);
        check("rst_com",  {8'h00, bus.fnd_com}, 12'h00F);
        check("rst_data", {4'h0, bus.fnd_data}, 12'h0FF);

        rst = 1'b1;
        @(negedge clk);
        check("rel_d0", {bus.fnd_com, bus.fnd_data}, 12'hEC0);
        repeat (3) @(negedge clk);
        check("rel_hold", {bus.fnd_com, bus.fnd_data}, 12'hEC0);
        @(negedge clk);
        check("rel_d1", {bus.fnd_com, bus.fnd_data}, 12'hDC0);

        apply("m0_59_99", 1'b0, 99, 59, 0, 0);
        apply("m1_23_05", 1'b1, 0, 0, 5, 23);
        apply("oor_127",  1'b0, 127, 0, 0, 0);
        apply("m0_12_34", 1'b0, 34, 12, 48, 7);

        // Mode flips during digit 1: rest of this frame keeps the old view.
        wait_for_com(4'b1101, "mc_d1");
        bus.sw_mode = 1'b1;
        push_frame("mc_old", 1'b0, 34, 12, 48, 7, 2, 3);
        capture(2, 3);
        push_frame("mc_new", 1'b1, 34, 12, 48, 7, 0, 3);
        capture(0, 3);

        // Asynchronous reset between edges while digit 2 is showing.
        wait_for_com(4'b1011, "ar_d2");
        #2;
        rst = 1'b0;
        #1;
        check("ar_com",  {8'h00, bus.fnd_com}, 12'h00F);
        check("ar_data", {4'h0, bus.fnd_data}, 12'h0FF);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("ar_rel_d0", {bus.fnd_com, bus.fnd_data}, 12'hEC0);
        repeat (4) @(negedge clk);
        check("ar_rel_d1", {bus.fnd_com, bus.fnd_data}, 12'hDC0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
